inst_prefetch_queue: RTL and testbench
======================================

// Module: inst_prefetch_queue
// PURPOSE
//  Fetch front-end between the unified single-port Memory and the IF/ID register.
//  Fetches instructions into a small FIFO whenever the data stage does not own the memory port.
//  This hides the structural hazard caused by loads and stores sharing the port with fetch.
//  On a taken branch or jump it flushes and refetches from the new target.
//  Provides PC+instruction pairs with a valid flag; IF/ID inserts a NOP whenever valid is low.
// PARAMETERS
//  DEPTH     4   queue entries; power of two, >=2
//  XLEN      32  instruction and PC width
//  ADDR_W    6   word-address width driven to Memory
//  RESET_PC  0   fetch PC after reset
// PORTS
//  clk          in   1       rising-edge clock
//  rst          in   1       asynchronous, active-high reset
//  mem_busy     in   1       data access owns the memory port this cycle (EX_MEM MemRead|MemWrite)
//  mem_rdata    in   XLEN    instruction read combinationally at mem_addr in the same cycle
//  mem_req      out  1       fetch issued this cycle (drives the Memory address-mux select low)
//  mem_addr     out  ADDR_W  fetch_pc[ADDR_W+1:2]
//  redirect     in   1       flush and restart fetch (branch_condition|Jal|Jalr resolved)
//  redirect_pc  in   XLEN    new fetch target; bits[1:0] ignored (treated as 00)
//  halt         in   1       ecall decoded; stop fetching
//  stall        in   1       ID load-use stall; hold the head entry
//  out_valid    out  1       head entry valid
//  out_inst     out  XLEN    head instruction
//  out_pc       out  XLEN    head PC
//  count        out  log2(DEPTH)+1  occupancy, 0..DEPTH
// BEHAVIOUR
//  Reset (async, rst=1): fetch_pc=RESET_PC; rd_ptr=wr_ptr=count=0; state=RUN.
//    All outputs go to 0 except mem_addr = RESET_PC[ADDR_W+1:2].
//  State machine:
//    RUN: if halt & !redirect, go to HALTED.
//    HALTED: go to RUN only on redirect. No fetches in HALTED; the queue still drains.
//  deq = out_valid & !stall & !redirect.
//  push = state==RUN & !mem_busy & !redirect & (count<DEPTH | deq).
//    The halt cycle itself may still push.
//  mem_req = push. mem_addr is always driven from fetch_pc.
//  On push (clock edge): entry[wr_ptr] <= {fetch_pc, mem_rdata}; wr_ptr++; fetch_pc += 4.
//    fetch_pc wraps modulo 2^XLEN.
//  On deq: rd_ptr++. count updates by push-deq, so simultaneous push and deq leaves count unchanged.
//    Both pointers wrap modulo DEPTH.
//  Full (count==DEPTH) with deq: push is allowed and count stays DEPTH.
//  Empty with push: count becomes 1 and out_valid=1 from the next cycle.
//    Fetch-to-output latency is 1 cycle; there is no same-cycle bypass.
//  out_valid = (count!=0) & !redirect. out_inst/out_pc come combinationally from entry[rd_ptr].
//  Redirect (highest priority) at the clock edge:
//    rd_ptr=wr_ptr=count=0; fetch_pc={redirect_pc[XLEN-1:2],2'b00}; state=RUN.
//    No push and no deq that cycle; stall and halt are ignored.
//    The first target instruction is fetched on the following cycle at the earliest.
//  mem_busy=1: no push; the queue continues to drain.
//    Back-to-back busy cycles only reduce occupancy.
//  stall=1: head held and the queue keeps filling up to DEPTH.
//  Reset asserted mid-operation: everything clears immediately and asynchronously.
//    Entries present before reset are never presented afterwards.
//    Fetch resumes at RESET_PC on the first edge after rst falls.
// TESTING
//  1. rst 1->0, mem_busy=0, memory word k = k:
//     out_valid=1 from cycle 2; out_pc 0,4,8,...; out_inst 0,1,2,...; count stays 1.
//  2. stall=1 for 6 cycles:
//     count reaches 4 and holds; mem_req=0 while full; out_pc unchanged;
//     after release, PCs continue in order with no gaps.
//  3. mem_busy=1 for 3 cycles with count=2 and stall=0:
//     two valid outputs, then out_valid=0; fetch_pc is unchanged across the busy window.
//  4. redirect=1, redirect_pc=0x23 with count=3:
//     out_valid=0 that cycle; next cycle count=0 and mem_addr=8;
//     first valid out_pc=0x20 one cycle later.
//  5. halt=1 at fetch_pc=0x10:
//     entry 0x10 is pushed, then mem_req=0 and the queue drains to empty;
//     redirect to 0x40 resumes with out_pc=0x40.
//  6. rst asserted while count=3 and stall=1:
//     out_valid=0 and count=0 immediately; first output after release is PC 0.

Source files
------------

// File: rtl/inst_prefetch_queue.sv
// inst_prefetch_queue: fetch FIFO that fills from the shared memory port whenever the data stage leaves it idle
module inst_prefetch_queue #(
  parameter int DEPTH = 4,
  parameter int XLEN = 32,
  parameter int ADDR_W = 6,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       mem_busy_i,
  input  logic [XLEN-1:0]            mem_rdata_i,
  output logic                       mem_req_o,
  output logic [ADDR_W-1:0]          mem_addr_o,
  input  logic                       redirect_i,
  input  logic [XLEN-1:0]            redirect_pc_i,
  input  logic                       halt_i,
  input  logic                       stall_i,
  output logic                       out_valid_o,
  output logic [XLEN-1:0]            out_inst_o,
  output logic [XLEN-1:0]            out_pc_o,
  output logic [$clog2(DEPTH):0]     count_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  typedef enum logic {RUN, HALTED} state_t;
  state_t state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [2*XLEN-1:0] entry_q [DEPTH];
  logic [2*XLEN-1:0] head;
  logic push, deq;
  assign out_valid_o = (count_q != '0) & !redirect_i;
  assign head = entry_q[rd_ptr_q];
  assign out_pc_o = out_valid_o ? head[2*XLEN-1:XLEN] : '0;
  assign out_inst_o = out_valid_o ? head[XLEN-1:0] : '0;
  assign mem_addr_o = fetch_pc_q[ADDR_W+1:2];
  assign mem_req_o = push;
  assign count_o = count_q;
  // rst gates push so mem_req stays low while reset is held
  always_comb begin
    deq = out_valid_o & !stall_i & !redirect_i;
    push = !rst & (state_q == RUN) & !mem_busy_i & !redirect_i & ((count_q != FULL) | deq);
    state_d = redirect_i ? RUN : (state_q == RUN && halt_i) ? HALTED : state_q;
    fetch_pc_d = redirect_i ? (redirect_pc_i & ~XLEN'(3)) : push ? fetch_pc_q + XLEN'(4) : fetch_pc_q;
    wr_ptr_d = redirect_i ? '0 : wr_ptr_q + PW'(push);
    rd_ptr_d = redirect_i ? '0 : rd_ptr_q + PW'(deq);
    count_d = redirect_i ? '0 : count_q + CW'(push) - CW'(deq);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      fetch_pc_q <= RESET_PC;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      fetch_pc_q <= fetch_pc_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q <= count_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) entry_q[wr_ptr_q] <= {fetch_pc_q, mem_rdata_i};
  end
endmodule

// File: tb/tb_inst_prefetch_queue.sv
// tb_inst_prefetch_queue: directed stimulus with a PC scoreboard checked by an independent output monitor
module tb_inst_prefetch_queue;
  logic clk = 0, rst = 1, mem_busy = 0, redirect = 0, halt = 0, stall = 0;
  logic [31:0] mem_rdata, redirect_pc = '0, out_inst, out_pc;
  logic mem_req, out_valid;
  logic [5:0] mem_addr;
  logic [2:0] count;
  int n_checks = 0, n_fail = 0;
  logic [31:0] exp_q[$];
  inst_prefetch_queue dut (
    .clk(clk), .rst(rst), .mem_busy_i(mem_busy), .mem_rdata_i(mem_rdata),
    .mem_req_o(mem_req), .mem_addr_o(mem_addr), .redirect_i(redirect),
    .redirect_pc_i(redirect_pc), .halt_i(halt), .stall_i(stall),
    .out_valid_o(out_valid), .out_inst_o(out_inst), .out_pc_o(out_pc), .count_o(count)
  );
  always #5 clk = ~clk;
  assign mem_rdata = 32'(mem_addr);
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic expect_from(input logic [31:0] pc, input int n);
    exp_q.delete();
    for (int i = 0; i < n; i++) exp_q.push_back(pc + 32'(4 * i));
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  always @(negedge clk) begin
    if (out_valid && !stall && !redirect) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_output: got pc %0h expected none", out_pc);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        check("out_pc", out_pc, e);
        check("out_inst", out_inst, (e >> 2) & 32'd63);
      end
    end
  end
  initial begin
    expect_from(32'h0, 64);
    repeat (2) tick();
    check("rst_count", 32'(count), 0);
    check("rst_valid", 32'(out_valid), 0);
    check("rst_req", 32'(mem_req), 0);
    check("rst_addr", 32'(mem_addr), 0);
    rst = 0;
    #1;
    check("first_valid_latency", 32'(out_valid), 0);
    tick();
    check("first_valid", 32'(out_valid), 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("steady_count", 32'(count), 1);
    end
    stall = 1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      check("stall_count", 32'(count), 32'(i + 1 > 4 ? 4 : i + 1));
      if (i >= 3) check("full_no_req", 32'(mem_req), 0);
    end
    stall = 0;
    mem_busy = 1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      check("busy_count", 32'(count), 32'(4 - i < 0 ? 0 : 4 - i));
      check("busy_valid", 32'(out_valid), 32'(i < 4));
      check("busy_req", 32'(mem_req), 0);
      check("busy_addr", 32'(mem_addr), 9);
    end
    mem_busy = 0;
    stall = 1;
    repeat (3) tick();
    check("pre_redirect_count", 32'(count), 3);
    stall = 0;
    redirect = 1;
    redirect_pc = 32'h23;
    expect_from(32'h20, 16);
    #1;
    check("redirect_valid", 32'(out_valid), 0);
    check("redirect_req", 32'(mem_req), 0);
    @(posedge clk);
    #1 redirect = 0;
    #1;
    check("post_redirect_count", 32'(count), 0);
    check("post_redirect_addr", 32'(mem_addr), 8);
    check("post_redirect_valid", 32'(out_valid), 0);
    tick();
    check("target_valid", 32'(out_valid), 1);
    check("target_pc", out_pc, 32'h20);
    repeat (2) tick();
    redirect = 1;
    redirect_pc = 32'h10;
    expect_from(32'h10, 1);
    tick();
    redirect = 0;
    halt = 1;
    #1;
    check("halt_cycle_req", 32'(mem_req), 1);
    check("halt_cycle_addr", 32'(mem_addr), 4);
    tick();
    halt = 0;
    #1;
    check("halted_req", 32'(mem_req), 0);
    check("halted_count", 32'(count), 1);
    check("halted_valid", 32'(out_valid), 1);
    for (int i = 0; i < 2; i++) begin
      tick();
      check("drained_count", 32'(count), 0);
      check("drained_valid", 32'(out_valid), 0);
      check("drained_req", 32'(mem_req), 0);
    end
    check("halt_sb_empty", 32'(exp_q.size()), 0);
    redirect = 1;
    redirect_pc = 32'h40;
    expect_from(32'h40, 16);
    tick();
    redirect = 0;
    tick();
    check("resume_pc", out_pc, 32'h40);
    tick();
    stall = 1;
    repeat (2) tick();
    check("pre_reset_count", 32'(count), 3);
    #2 rst = 1;
    expect_from(32'h0, 16);
    #1;
    check("async_rst_valid", 32'(out_valid), 0);
    check("async_rst_count", 32'(count), 0);
    check("async_rst_addr", 32'(mem_addr), 0);
    tick();
    rst = 0;
    stall = 0;
    tick();
    check("post_reset_pc", out_pc, 32'h0);
    repeat (5) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
